// File: rtl/sdram_port_ctrl.sv
// Single-outstanding Avalon-MM master that turns one-cycle read/write pulses into
// bus transactions, with sticky error/timeout flags and registered outputs.
module sdram_port_ctrl #(
  parameter int ADDR_W  = 25,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_en_sdram,
  input  logic              write_en_sdram,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic              clear_error,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              dataRead_sdram,
  output logic              dataWritten_sdram,
  output logic [DATA_W-1:0] rdata_out,
  output logic              busy,
  output logic              req_error,
  output logic              timeout_flag,
  output logic [1:0]        dbg_state_o
);

  // Handshake: a command is held on avm_* while avm_waitrequest=1 and is
  // accepted at the first rising edge that samples avm_waitrequest=0.
  typedef enum logic [1:0] {IDLE = 2'd0, RD_REQ = 2'd1, RD_WAIT = 2'd2, WR_REQ = 2'd3} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                drd_q, drd_d;
  logic                dwr_q, dwr_d;
  logic                busy_q, busy_d;
  logic                rerr_q, rerr_d;
  logic                to_q, to_d;
  logic                err_set, to_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      drd_q   <= 1'b0;
      dwr_q   <= 1'b0;
      busy_q  <= 1'b0;
      rerr_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      drd_q   <= drd_d;
      dwr_q   <= dwr_d;
      busy_q  <= busy_d;
      rerr_q  <= rerr_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (read_en_sdram)       state_d = RD_REQ;
        else if (write_en_sdram) state_d = WR_REQ;
      end
      RD_REQ: begin
        if (!avm_waitrequest) state_d = avm_readdatavalid ? IDLE : RD_WAIT;
      end
      RD_WAIT: begin
        if (avm_readdatavalid || cnt_q == TO_LAST) state_d = IDLE;
      end
      WR_REQ: begin
        if (!avm_waitrequest) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    drd_d   = 1'b0;
    dwr_d   = 1'b0;
    err_set = 1'b0;
    to_set  = 1'b0;
    case (state_q)
      IDLE: begin
        err_set = read_en_sdram & write_en_sdram;
        if (read_en_sdram) begin
          addr_d = addr_in;
        end else if (write_en_sdram) begin
          addr_d  = addr_in;
          wdata_d = wdata_in;
        end
      end
      RD_REQ: begin
        err_set = read_en_sdram | write_en_sdram;
        if (!avm_waitrequest) begin
          cnt_d = '0;
          if (avm_readdatavalid) begin
            rdata_d = avm_readdata;
            drd_d   = 1'b1;
          end
        end
      end
      RD_WAIT: begin
        err_set = read_en_sdram | write_en_sdram;
        if (avm_readdatavalid) begin
          rdata_d = avm_readdata;
          drd_d   = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          to_set = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WR_REQ: begin
        err_set = read_en_sdram | write_en_sdram;
        if (!avm_waitrequest) dwr_d = 1'b1;
      end
      default: ;
    endcase
    // Commands and busy follow the state being entered so they stay registered.
    rd_d   = (state_d == RD_REQ);
    wr_d   = (state_d == WR_REQ);
    busy_d = (state_d != IDLE);
    rerr_d = err_set | (rerr_q & ~clear_error);
    to_d   = to_set  | (to_q   & ~clear_error);
  end

  assign avm_address       = addr_q;
  assign avm_writedata     = wdata_q;
  assign avm_read          = rd_q;
  assign avm_write         = wr_q;
  assign dataRead_sdram    = drd_q;
  assign dataWritten_sdram = dwr_q;
  assign rdata_out         = rdata_q;
  assign busy              = busy_q;
  assign req_error         = rerr_q;
  assign timeout_flag      = to_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_sdram_port_ctrl.sv
// Randomized bench for sdram_port_ctrl: driver tasks play control unit and slave,
// a negedge monitor checks bus commands and completion pulses against queued expectations.
`timescale 1ns/1ps
module tb_sdram_port_ctrl;

  localparam int AW = 25;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          read_en = 1'b0, write_en = 1'b0, clear_error = 1'b0;
  logic [AW-1:0] addr_in = '0;
  logic [DW-1:0] wdata_in = '0;
  logic [AW-1:0] avm_address;
  logic          avm_read, avm_write;
  logic [DW-1:0] avm_writedata;
  logic          avm_waitrequest = 1'b0;
  logic [DW-1:0] avm_readdata = '0;
  logic          avm_readdatavalid = 1'b0;
  logic          data_read, data_written;
  logic [DW-1:0] rdata_out;
  logic          busy, req_error, timeout_flag;
  logic [1:0]    dbg_state;

  sdram_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .read_en_sdram(read_en), .write_en_sdram(write_en),
    .addr_in(addr_in), .wdata_in(wdata_in), .clear_error(clear_error),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .dataRead_sdram(data_read), .dataWritten_sdram(data_written),
    .rdata_out(rdata_out), .busy(busy), .req_error(req_error),
    .timeout_flag(timeout_flag), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic          is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            dur;
  } cmd_t;

  cmd_t          exp_cmd_q[$];
  logic [DW-1:0] exp_q[$];      // read words expected with dataRead_sdram
  logic [DW-1:0] exp_wr_q[$];   // write words expected with dataWritten_sdram

  int tests = 0;
  int fails = 0;

  // reference model state
  logic          m_err = 1'b0;
  logic          m_to = 1'b0;
  logic [DW-1:0] m_rdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor
  cmd_t cur;
  bit   cmd_active = 0;
  int   cmd_len = 0;
  logic prev_rd = 0, prev_wr = 0;

  always @(negedge clk) begin
    if (rst) begin
      cmd_active = 0;
    end else begin
      if (avm_read && avm_write) chk("rd_wr_overlap", 1, 0);
      if ((avm_read || avm_write) && !cmd_active) begin
        if (exp_cmd_q.size() == 0) begin
          chk("cmd_unexpected", {avm_write, avm_address}, 0);
        end else begin
          cur = exp_cmd_q.pop_front();
          chk("cmd_kind", avm_write, cur.is_wr);
          chk("cmd_addr", avm_address, cur.addr);
          if (cur.is_wr) chk("cmd_wdata", avm_writedata, cur.data);
        end
        cmd_active = 1;
        cmd_len = 1;
      end else if (avm_read || avm_write) begin
        cmd_len++;
        chk("cmd_addr_stable", avm_address, cur.addr);
        if (cur.is_wr) chk("cmd_wdata_stable", avm_writedata, cur.data);
      end else if (cmd_active) begin
        cmd_active = 0;
        if (cur.dur >= 0) chk("cmd_len", cmd_len, cur.dur);
      end
      if (data_read) begin
        if (exp_q.size() == 0) chk("rd_pulse_unexpected", rdata_out, 0);
        else chk("rdata", rdata_out, exp_q.pop_front());
      end
      if (data_written) begin
        if (exp_wr_q.size() == 0) chk("wr_pulse_unexpected", avm_writedata, 0);
        else chk("wr_done_data", avm_writedata, exp_wr_q.pop_front());
      end
      if (data_read && prev_rd) chk("rd_pulse_width", 2, 1);
      if (data_written && prev_wr) chk("wr_pulse_width", 2, 1);
    end
    prev_rd = data_read;
    prev_wr = data_written;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    read_en = 1'b0;
    write_en = 1'b0;
    clear_error = 1'b0;
  endtask

  task automatic poke();
    if ($urandom_range(0, 1) == 1) read_en = 1'b1;
    else write_en = 1'b1;
    addr_in = AW'($urandom);
    m_err = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req_error"}, req_error, m_err);
    chk({tag, "_timeout"}, timeout_flag, m_to);
    chk({tag, "_rdata_hold"}, rdata_out, m_rdata);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input int w, input int lat, input bit both, input bit pk);
    cmd_t c;
    c.is_wr = 1'b0; c.addr = addr; c.data = '0; c.dur = w + 1;
    exp_cmd_q.push_back(c);
    read_en = 1'b1;
    addr_in = addr;
    if (both) begin
      write_en = 1'b1;
      wdata_in = DW'($urandom);
      m_err = 1'b1;
    end
    step();
    chk("rd_busy_start", busy, 1);
    if (pk && lat == 0) poke();
    for (int i = 0; i < w; i++) begin
      avm_waitrequest = 1'b1;
      step();
    end
    avm_waitrequest = 1'b0;
    if (lat == 0) begin
      avm_readdatavalid = 1'b1;
      avm_readdata = data;
      exp_q.push_back(data);
      m_rdata = data;
      step();
      avm_readdatavalid = 1'b0;
    end else begin
      step();
      if (pk) poke();
      if (lat <= TO) begin
        for (int i = 1; i < lat; i++) step();
        avm_readdatavalid = 1'b1;
        avm_readdata = data;
        exp_q.push_back(data);
        m_rdata = data;
        step();
        avm_readdatavalid = 1'b0;
      end else begin
        for (int i = 0; i < TO; i++) step();
        m_to = 1'b1;
        chk("to_busy_clear", busy, 0);
        chk("to_flag", timeout_flag, 1);
      end
    end
    avm_readdata = DW'($urandom);
    step();
    check_idle("rd");
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input int w, input bit pk);
    cmd_t c;
    c.is_wr = 1'b1; c.addr = addr; c.data = data; c.dur = w + 1;
    exp_cmd_q.push_back(c);
    write_en = 1'b1;
    addr_in = addr;
    wdata_in = data;
    step();
    chk("wr_busy_start", busy, 1);
    if (pk) poke();
    for (int i = 0; i < w; i++) begin
      avm_waitrequest = 1'b1;
      avm_readdatavalid = 1'($urandom_range(0, 1));
      avm_readdata = DW'($urandom);
      step();
    end
    avm_waitrequest = 1'b0;
    avm_readdatavalid = 1'($urandom_range(0, 1));
    exp_wr_q.push_back(data);
    step();
    avm_readdatavalid = 1'b0;
    step();
    check_idle("wr");
  endtask

  task automatic do_clear();
    clear_error = 1'b1;
    step();
    m_err = 1'b0;
    m_to = 1'b0;
    chk("clear_req_error", req_error, 0);
    chk("clear_timeout", timeout_flag, 0);
  endtask

  initial begin
    cmd_t c;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_avm_read", avm_read, 0);
    chk("rst_avm_write", avm_write, 0);
    chk("rst_addr", avm_address, 0);
    chk("rst_rdata", rdata_out, 0);
    chk("rst_flags", {req_error, timeout_flag, data_read, data_written}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();

    // directed corners
    do_read(25'h0001234, 32'hDEADBEEF, 0, 1, 0, 0);
    do_write(25'h0000010, 32'h00FF00FF, 3, 0);
    do_read(25'h0000ABC, 32'h12345678, 1, 2, 1, 0);
    do_clear();
    do_read(25'h0000777, 32'hCAFEF00D, 0, TO + 1, 0, 0);
    do_clear();
    do_read(25'h1FFFFFF, 32'hA5A5A5A5, 2, 3, 0, 1);
    do_read(25'h0000055, 32'h0BADF00D, 0, 0, 0, 0);
    do_read(25'h0000056, 32'h600DF00D, 1, TO, 0, 0);
    do_clear();

    // reset mid-write with the slave stalling
    c.is_wr = 1'b1; c.addr = 25'h0000321; c.data = 32'h13572468; c.dur = -1;
    exp_cmd_q.push_back(c);
    write_en = 1'b1;
    addr_in = c.addr;
    wdata_in = c.data;
    step();
    avm_waitrequest = 1'b1;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_avm_write", avm_write, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_regs", {avm_address, avm_writedata, rdata_out}, 0);
    chk("mid_rst_flags", {req_error, timeout_flag, data_read, data_written}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    avm_waitrequest = 1'b0;
    m_err = 1'b0;
    m_to = 1'b0;
    m_rdata = '0;
    step();
    check_idle("post_rst");
    do_read(25'h0000099, 32'h89ABCDEF, 1, 1, 0, 0);

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 1) == 1)
        do_read(AW'($urandom), DW'($urandom), $urandom_range(0, 3),
                $urandom_range(0, TO + 2), $urandom_range(0, 7) == 0,
                $urandom_range(0, 5) == 0);
      else
        do_write(AW'($urandom), DW'($urandom), $urandom_range(0, 3),
                 $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) do_clear();
    end

    repeat (3) step();
    chk("cmd_q_empty", exp_cmd_q.size(), 0);
    chk("rd_q_empty", exp_q.size(), 0);
    chk("wr_q_empty", exp_wr_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
